// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: majority-votes a triplicated state register and sequences scrub/repair resyncs.
//   clk, rst (async, active-high)
//   en                     enable supervision
//   state_a/b/c            the three protected copies
//   voted, mismatch        combinational majority and disagreement flag
//   resync, resync_val     load strobe and registered value for all three copies
//   err_count, clr_count   saturating mismatch counter and its synchronous clear
//   err_fatal, clr_fault   sticky repair-failure flag and its release
//   busy                   repair in progress (RESYNC or VERIFY)
module tmr_scrub_ctrl #(
  parameter int WIDTH        = 1,
  parameter int SCRUB_PERIOD = 256,
  parameter int RETRY_MAX    = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] state_a,
  input  logic [WIDTH-1:0] state_b,
  input  logic [WIDTH-1:0] state_c,
  output logic [WIDTH-1:0] voted,
  output logic             resync,
  output logic [WIDTH-1:0] resync_val,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_count,
  output logic             err_fatal,
  input  logic             clr_fault,
  output logic             busy
);
  localparam int TW = $clog2(SCRUB_PERIOD);
  localparam int RW = $clog2(RETRY_MAX + 1);
  typedef enum logic [2:0] {IDLE, CHECK, RESYNC, VERIFY, FAULT} state_t;
  state_t state, nxt;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic expired, last_try;
  assign voted    = (state_a & state_b) | (state_b & state_c) | (state_a & state_c);
  assign mismatch = (state_a != state_b) | (state_b != state_c);
  assign expired  = timer == TW'(SCRUB_PERIOD - 1);
  assign last_try = retry == RW'(RETRY_MAX - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      retry      <= '0;
      resync_val <= '0;
      err_count  <= '0;
    end else begin
      state <= nxt;
      // the timer only runs while CHECK persists; every exit (to IDLE or RESYNC) restarts it
      timer <= (state == CHECK && nxt == CHECK) ? timer + TW'(1) : '0;
      if (nxt == RESYNC) resync_val <= voted;
      if (state == VERIFY && nxt == RESYNC) retry <= retry + RW'(1);
      else if ((state == VERIFY && nxt == CHECK) || (state == FAULT && nxt == IDLE)) retry <= '0;
      // only CHECK-phase mismatches are counted; failed verifies are not new errors
      err_count <= clr_count ? '0 :
                   (state == CHECK && en && mismatch && !(&err_count)) ? err_count + CNT_W'(1) :
                   err_count;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = en ? CHECK : IDLE;
      CHECK:   nxt = !en ? IDLE : (mismatch || expired) ? RESYNC : CHECK;
      RESYNC:  nxt = VERIFY;
      VERIFY:  nxt = !mismatch ? CHECK : last_try ? FAULT : RESYNC;
      FAULT:   nxt = clr_fault ? IDLE : FAULT;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    resync    = state == RESYNC;
    busy      = state == RESYNC || state == VERIFY;
    err_fatal = state == FAULT;
  end
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb_tmr_scrub_ctrl: directed cycle table plus async-reset sequence for tmr_scrub_ctrl.
module tb_tmr_scrub_ctrl;
  logic clk = 0, rst = 1, en = 0, clr_count = 0, clr_fault = 0;
  logic [0:0] state_a = 1, state_b = 1, state_c = 1, voted, resync_val;
  logic resync, mismatch, err_fatal, busy;
  logic [1:0] err_count;
  int checks = 0, errors = 0;
  typedef struct {
    logic en, a, b, c, cc, cf, rs, rv, bz, ft;
    logic [1:0] ec;
  } vec_t;
  vec_t tbl[$];
  tmr_scrub_ctrl #(.WIDTH(1), .SCRUB_PERIOD(8), .RETRY_MAX(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .state_a(state_a), .state_b(state_b), .state_c(state_c),
    .voted(voted), .resync(resync), .resync_val(resync_val), .mismatch(mismatch),
    .err_count(err_count), .clr_count(clr_count), .err_fatal(err_fatal),
    .clr_fault(clr_fault), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask
  task automatic add(input int n, input logic [2:0] abc, input logic e, cc, cf, rs, rv, bz, ft,
                     input logic [1:0] ec);
    for (int i = 0; i < n; i++)
      tbl.push_back('{e, abc[2], abc[1], abc[0], cc, cf, rs, rv, bz, ft, ec});
  endtask
  task automatic chk_all(input int row, input logic rs, rv, bz, ft, input logic [1:0] ec);
    logic [1:0] sum;
    sum = 2'(state_a) + 2'(state_b) + 2'(state_c);
    chk("voted", row, 8'(voted), 8'(sum >= 2));
    chk("mismatch", row, 8'(mismatch), 8'(!(state_a == state_b && state_b == state_c)));
    chk("resync", row, 8'(resync), 8'(rs));
    chk("resync_val", row, 8'(resync_val), 8'(rv));
    chk("busy", row, 8'(busy), 8'(bz));
    chk("err_fatal", row, 8'(err_fatal), 8'(ft));
    chk("err_count", row, 8'(err_count), 8'(ec));
  endtask
  initial begin
    //   n  abc    en cc cf rs rv bz ft ec
    add(1, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0);  // idle, en low
    add(9, 3'b111, 1, 0, 0, 0, 0, 0, 0, 0);  // enter CHECK, timer 0..7
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 0);  // scrub resync
    add(1, 3'b111, 1, 0, 0, 0, 1, 1, 0, 0);  // verify
    add(8, 3'b111, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 0);  // second scrub, 10 cycles later
    add(1, 3'b111, 1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 3'b111, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 3'b101, 1, 0, 0, 0, 1, 0, 0, 0);  // single upset on b
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 1);
    add(1, 3'b111, 1, 0, 0, 0, 1, 1, 0, 1);
    add(1, 3'b111, 1, 0, 0, 0, 1, 0, 0, 1);  // back in CHECK 3 cycles after upset
    add(1, 3'b110, 1, 0, 0, 0, 1, 0, 0, 1);  // c stuck at 0
    for (int i = 0; i < 3; i++) begin
      add(1, 3'b110, 1, 0, 0, 1, 1, 1, 0, 2);
      add(1, 3'b110, 1, 0, 0, 0, 1, 1, 0, 2);
    end
    add(1, 3'b110, 1, 0, 0, 0, 1, 0, 1, 2);  // FAULT, no further counting
    add(1, 3'b110, 1, 1, 0, 0, 1, 0, 1, 2);  // clr_count inside FAULT
    add(1, 3'b111, 1, 0, 1, 0, 1, 0, 1, 0);  // clr_fault
    add(1, 3'b111, 1, 0, 0, 0, 1, 0, 0, 0);  // IDLE
    add(1, 3'b101, 1, 0, 0, 0, 1, 0, 0, 0);  // upset 1
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 1);
    add(1, 3'b111, 1, 0, 0, 0, 1, 1, 0, 1);
    add(1, 3'b110, 1, 0, 0, 0, 1, 0, 0, 1);  // upset 2
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 2);
    add(1, 3'b111, 1, 0, 0, 0, 1, 1, 0, 2);
    add(1, 3'b011, 1, 0, 0, 0, 1, 0, 0, 2);  // upset 3
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 3);
    add(1, 3'b111, 1, 0, 0, 0, 1, 1, 0, 3);
    add(1, 3'b001, 1, 0, 0, 0, 1, 0, 0, 3);  // upset 4, votes 0, saturated
    add(1, 3'b000, 1, 0, 0, 1, 0, 1, 0, 3);
    add(1, 3'b000, 1, 0, 0, 0, 0, 1, 0, 3);
    add(1, 3'b100, 1, 0, 0, 0, 0, 0, 0, 3);  // upset 5
    add(1, 3'b000, 1, 0, 0, 1, 0, 1, 0, 3);
    add(1, 3'b000, 1, 0, 0, 0, 0, 1, 0, 3);
    add(1, 3'b011, 1, 1, 0, 0, 0, 0, 0, 3);  // upset 6 with clr_count
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 0);
    add(1, 3'b111, 1, 0, 0, 0, 1, 1, 0, 0);
    add(7, 3'b111, 1, 0, 0, 0, 1, 0, 0, 0);  // timer 0..6
    add(1, 3'b101, 1, 0, 0, 0, 1, 0, 0, 0);  // upset on timer expiry
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 1);
    add(1, 3'b111, 1, 0, 0, 0, 1, 1, 0, 1);
    add(8, 3'b111, 1, 0, 0, 0, 1, 0, 0, 1);  // timer restarted from 0
    add(1, 3'b111, 1, 0, 0, 1, 1, 1, 0, 1);
    #2;
    chk_all(-1, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 0;
    foreach (tbl[i]) begin
      @(negedge clk);
      {en, state_a, state_b, state_c, clr_count, clr_fault} =
        {tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].cc, tbl[i].cf};
      #1 chk_all(i, tbl[i].rs, tbl[i].rv, tbl[i].bz, tbl[i].ft, tbl[i].ec);
    end
    @(negedge clk) {state_a, state_b, state_c} = 3'b111;
    @(negedge clk) state_b = 0;
    @(posedge clk) #1 chk("pre_rst_resync", -2, 8'(resync), 8'd1);
    #2 rst = 1;
    #1 chk_all(-3, 0, 0, 0, 0, 0);
    @(negedge clk) begin state_b = 1; rst = 0; end
    @(negedge clk) state_b = 0;
    @(posedge clk) #1 begin
      chk("rst_then_check_resync", -4, 8'(resync), 8'd1);
      chk("rst_then_check_val", -4, 8'(resync_val), 8'd1);
      chk("rst_then_check_count", -4, 8'(err_count), 8'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
